// File: rtl/image_line_feeder_pkg.sv
// Shared types and sizing helpers for the image line feeder.
package image_line_feeder_pkg;

  localparam int unsigned DEF_INTEGER_BITS    = 8;
  localparam int unsigned DEF_FIXED_POINT_BITS = 4;
  localparam int unsigned DEF_PRIME_LINES     = 4;
  localparam int unsigned PIX_W = DEF_INTEGER_BITS + DEF_FIXED_POINT_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_DRAIN
  } feeder_state_e;

  // Width needed to hold a count of 0..n inclusive.
  function automatic int unsigned credit_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Index width for 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CREDIT_W = credit_w(DEF_PRIME_LINES);

endpackage

// File: rtl/feeder_credit_counter.sv
// Line-credit counter: loads on image start, returns on interrupt,
// consumes on line commit, and flags credit overflow stickily.
module feeder_credit_counter
  import image_line_feeder_pkg::*;
#(
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_commit,
  input  logic             i_intr,
  output logic [CNT_W-1:0] o_credits,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(PRIME_LINES);

  logic [CNT_W-1:0] r_credits;
  logic             r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credits <= '0;
      r_err     <= 1'b0;
    end else if (i_load) begin
      r_credits <= MAX_CREDITS;
    end else begin
      case ({i_intr, i_commit})
        2'b10: begin
          if (r_credits == MAX_CREDITS) r_err <= 1'b1;
          else                          r_credits <= r_credits + CNT_W'(1);
        end
        2'b01: begin
          if (r_credits != '0) r_credits <= r_credits - CNT_W'(1);
        end
        // A return colliding with a commit leaves the count unchanged.
        default: ;
      endcase
    end
  end

  assign o_credits = r_credits;
  assign o_err     = r_err;

endmodule

// File: rtl/image_line_feeder.sv
// Streams an image line by line from a synchronous-read memory into a
// 3x3 window generator, gated by line credits returned via interrupt.
module image_line_feeder
  import image_line_feeder_pkg::*;
#(
  parameter int unsigned INTEGER_BITS     = DEF_INTEGER_BITS,
  parameter int unsigned FIXED_POINT_BITS = DEF_FIXED_POINT_BITS,
  parameter int unsigned IMG_WIDTH        = 512,
  parameter int unsigned IMG_HEIGHT       = 512,
  parameter int unsigned PRIME_LINES      = DEF_PRIME_LINES,
  parameter int unsigned ADDR_W           = 18
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  input  logic [ADDR_W-1:0]                        i_base_addr,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_mem_rd,
  output logic [ADDR_W-1:0]                        o_mem_addr,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_mem_data,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_pixel_data,
  output logic                                     o_pixel_data_valid,
  input  logic                                     i_intr,
  output logic                                     o_err
);

  localparam int unsigned PIX_WIDTH = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int unsigned CNT_W     = credit_w(PRIME_LINES);
  localparam int unsigned COL_W     = idx_w(IMG_WIDTH);
  localparam int unsigned ROW_W     = idx_w(IMG_HEIGHT);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  feeder_state_e          r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_mem_rd;
  logic                   r_rd_d1;
  logic                   r_drain;
  logic [PIX_WIDTH-1:0]   r_pix_data;
  logic                   r_pix_valid;

  logic                   w_load;
  logic                   w_commit;
  logic [CNT_W-1:0]       w_credits;
  logic                   w_err;

  assign w_load   = (r_state == S_IDLE) && i_start;
  assign w_commit = (r_state == S_FETCH) && (r_col == LAST_COL);

  feeder_credit_counter #(
    .PRIME_LINES (PRIME_LINES),
    .CNT_W       (CNT_W)
  ) u_credit (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_commit  (w_commit),
    .i_intr    (i_intr),
    .o_credits (w_credits),
    .o_err     (w_err)
  );

  // Control FSM, address/position counters and the two-stage read pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_rd_d1     <= 1'b0;
      r_drain     <= 1'b0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_rd_d1     <= r_mem_rd;
      r_pix_valid <= r_rd_d1;
      if (r_rd_d1) r_pix_data <= i_mem_data;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Credit is only consulted here, so lines are never split.
          if (w_credits != '0) begin
            r_mem_rd <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_col == LAST_COL) begin
            r_col    <= '0;
            r_row    <= r_row + ROW_W'(1);
            r_mem_rd <= 1'b0;
            if (r_row == LAST_ROW) begin
              r_drain <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_CHECK;
            end
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_mem_rd           = r_mem_rd;
  assign o_mem_addr         = r_addr;
  assign o_pixel_data       = r_pix_data;
  assign o_pixel_data_valid = r_pix_valid;
  assign o_err              = w_err;

endmodule

// File: tb/tb_image_line_feeder.sv
// Directed bench for image_line_feeder on an 8x6 image with 4 line credits.
module tb_image_line_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned PL = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned PW = 12;
  localparam logic [AW-1:0] BASE = 18'h100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, mem_rd, pix_valid, intr, err;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_q = '0;
  logic [PW-1:0] pix_data;

  always #5 clk = ~clk;

  image_line_feeder #(
    .INTEGER_BITS     (8),
    .FIXED_POINT_BITS (4),
    .IMG_WIDTH        (W),
    .IMG_HEIGHT       (H),
    .PRIME_LINES      (PL),
    .ADDR_W           (AW)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start            (start),
    .i_base_addr        (base_addr),
    .o_busy             (busy),
    .o_done             (done),
    .o_mem_rd           (mem_rd),
    .o_mem_addr         (mem_addr),
    .i_mem_data         (mem_q),
    .o_pixel_data       (pix_data),
    .o_pixel_data_valid (pix_valid),
    .i_intr             (intr),
    .o_err              (err)
  );

  // Synchronous-read memory whose contents equal the low address bits.
  always @(posedge clk) if (mem_rd) mem_q <= mem_addr[PW-1:0];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pix_cnt = 0;
  int done_cnt = 0;
  int last_valid_cyc = -100;
  logic [AW-1:0] exp_next = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Pixel order and done-timing monitor.
  always @(negedge clk) begin
    if (pix_valid) begin
      check("pixel", 64'(pix_data), 64'(exp_next[PW-1:0]));
      exp_next = exp_next + AW'(1);
      pix_cnt++;
      last_valid_cyc = cyc;
    end
    if (done) begin
      check("done_after_last_pixel", 64'(cyc), 64'(last_valid_cyc + 1));
      done_cnt++;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input bit accept);
    @(negedge clk);
    if (accept) exp_next = b;
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_intr();
    @(negedge clk);
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
  endtask

  // Returns at the negedge where a read of address t is in progress.
  task automatic wait_rd_addr(input string name, input logic [AW-1:0] t);
    bit found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == t) found = 1'b1;
    end
    check(name, 64'(found), 64'd1);
  endtask

  typedef struct {
    bit do_start;
    int n_intr;
    int wait_cyc;
    int exp_pix;
    bit exp_busy;
    int exp_done;
    bit exp_err;
    bit chk_quiet;
  } vec_t;

  vec_t vt[8];
  int   rd_seen;
  int   p0, d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; intr = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_rd",    64'(mem_rd), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_pix",   64'(pix_data), 64'd0);
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    rst_n = 1'b1;

    //       start intr wait  pix busy done err quiet
    vt[0] = '{1'b1, 0, 150, 32, 1'b1, 0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 0, 100, 32, 1'b1, 0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1,  30, 40, 1'b1, 0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1,  40, 48, 1'b0, 1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 4,   5, 48, 1'b0, 1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1,   5, 48, 1'b0, 1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 0, 150, 80, 1'b1, 1, 1'b1, 1'b1};
    vt[7] = '{1'b0, 2,  60, 96, 1'b0, 2, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_start) do_start(BASE, 1'b1);
      for (int k = 0; k < vt[i].n_intr; k++) pulse_intr();
      rd_seen = 0;
      for (int k = 0; k < vt[i].wait_cyc; k++) begin
        @(negedge clk);
        if (mem_rd) rd_seen++;
      end
      check($sformatf("v%0d_pixels", i), 64'(pix_cnt), 64'(vt[i].exp_pix));
      check($sformatf("v%0d_busy", i),   64'(busy), 64'(vt[i].exp_busy));
      check($sformatf("v%0d_done", i),   64'(done_cnt), 64'(vt[i].exp_done));
      check($sformatf("v%0d_err", i),    64'(err), 64'(vt[i].exp_err));
      if (vt[i].chk_quiet && vt[i].exp_pix == 32)
        check($sformatf("v%0d_rd_quiet", i), 64'(rd_seen), 64'd0);
    end

    // Reset clears the sticky error.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ignored start during FETCH, and a return colliding with the 4th commit.
    p0 = pix_cnt; d0 = done_cnt;
    do_start(BASE, 1'b1);
    wait_rd_addr("wait_col2", BASE + AW'(2));
    base_addr = 18'h200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_addr", 64'(mem_addr), 64'(BASE + AW'(3)));
    check("ign_start_busy", 64'(busy), 64'd1);
    wait_rd_addr("wait_line4_end", BASE + AW'(31));
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    repeat (60) @(negedge clk);
    check("coll_pixels", 64'(pix_cnt - p0), 64'd40);
    check("coll_busy",   64'(busy), 64'd1);
    pulse_intr();
    repeat (40) @(negedge clk);
    check("coll_tail_pixels", 64'(pix_cnt - p0), 64'd48);
    check("coll_done",        64'(done_cnt - d0), 64'd1);
    check("coll_busy_end",    64'(busy), 64'd0);

    // Reset mid-line at col 3, then restart from base with full credit.
    do_start(BASE, 1'b1);
    wait_rd_addr("wait_col3", BASE + AW'(3));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_rd",    64'(mem_rd), 64'd0);
    check("mid_rst_addr",  64'(mem_addr), 64'd0);
    check("mid_rst_pix",   64'(pix_data), 64'd0);
    check("mid_rst_valid", 64'(pix_valid), 64'd0);
    check("mid_rst_done",  64'(done), 64'd0);
    p0 = pix_cnt; d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_pixels", 64'(pix_cnt - p0), 64'd0);
    check("post_rst_no_done",   64'(done_cnt - d0), 64'd0);

    do_start(BASE, 1'b1);
    @(negedge clk);
    check("first_rd",      64'(mem_rd), 64'd1);
    check("first_rd_addr", 64'(mem_addr), 64'(BASE));
    repeat (2) @(negedge clk);
    check("first_valid",   64'(pix_valid), 64'd1);
    repeat (150) @(negedge clk);
    check("restart_pixels", 64'(pix_cnt - p0), 64'd32);
    check("restart_busy",   64'(busy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
